// File: rtl/dds_rom_arbiter.sv
// Shares one synchronous 64x8 quarter-wave sine ROM between NCH DDS channels (3-stage pipeline).
// Build macro DDS_ARB_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module dds_rom_arbiter #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic              clk_star,
  input  logic              reset,
  input  logic              en,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*8-1:0]  phase,
  output logic [NCH-1:0]    gnt,
  output logic [5:0]        rom_addr,
  input  logic [7:0]        rom_data,
  output logic              resp_valid,
  output logic [CH_W-1:0]   resp_ch,
  output logic [7:0]        sine,
  output logic [7:0]        full,
  output logic [7:0]        half,
  output logic              busy
);

  localparam logic [CH_W-1:0] LAST_ID = CH_W'(NCH - 1);
  localparam logic [NCH-1:0]  GNT_ONE = NCH'(1);

  // Search forward from start (wrapping at NCH-1) for the first eligible channel.
  function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0] elig,
                                            input logic [CH_W-1:0] start);
    logic [CH_W:0]   res;
    logic [CH_W-1:0] cur;
    res = '0;
    cur = start;
    for (int i = 0; i < NCH; i++) begin
      res = (!res[CH_W] && elig[cur]) ? {1'b1, cur} : res;
      cur = (cur == LAST_ID) ? '0 : cur + CH_W'(1);
    end
    return res;
  endfunction

  // Stage A registers
  logic [NCH-1:0]  gnt_q, gnt_d;
  logic [5:0]      rom_addr_q, rom_addr_d;
  logic            vld_a_q, vld_a_d;
  logic            sign_a_q, sign_a_d;
  logic            peak_a_q, peak_a_d;
  logic [CH_W-1:0] id_a_q, id_a_d;
  // Stage B registers
  logic            vld_b_q;
  logic            sign_b_q;
  logic            peak_b_q;
  logic [CH_W-1:0] id_b_q;
  // Stage C / output registers
  logic            resp_valid_q, resp_valid_d;
  logic [CH_W-1:0] resp_ch_q, resp_ch_d;
  logic [7:0]      sine_q, sine_d;
  logic [7:0]      full_q, full_d;
  logic [7:0]      half_q, half_d;
  logic            busy_q, busy_d;

  logic [NCH-1:0]  elig_s;
  logic [CH_W-1:0] start_s;
  logic [CH_W:0]   pick_s;
  logic            grant_s;
  logic [CH_W-1:0] win_id_s;
  logic [7:0]      win_phase_s;
  logic [7:0]      mag_s;

  // A channel granted last cycle must drop out for one cycle before it can win again.
  assign elig_s   = req & ~gnt_q;
  assign pick_s   = rr_pick(elig_s, start_s);
  assign grant_s  = en & pick_s[CH_W];
  assign win_id_s = pick_s[CH_W-1:0];

`ifdef DDS_ARB_PRIORITY_EN
  assign start_s = '0;
`else
  logic [CH_W-1:0] ptr_q, ptr_d;

  assign start_s = ptr_q;

  // Round-robin pointer advances past the winner, holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_s) begin
      ptr_d = (win_id_s == LAST_ID) ? '0 : win_id_s + CH_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_star or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Select the winning channel's phase byte.
  always_comb begin
    win_phase_s = 8'd0;
    for (int i = 0; i < NCH; i++) begin
      win_phase_s = (win_id_s == CH_W'(i)) ? phase[8*i +: 8] : win_phase_s;
    end
  end

  // Stage A: grant, fold the quadrant into a ROM address, flag the 90-degree peak.
  always_comb begin
    gnt_d      = '0;
    vld_a_d    = 1'b0;
    rom_addr_d = rom_addr_q;
    sign_a_d   = sign_a_q;
    peak_a_d   = peak_a_q;
    id_a_d     = id_a_q;
    if (grant_s) begin
      gnt_d      = GNT_ONE << win_id_s;
      vld_a_d    = 1'b1;
      sign_a_d   = win_phase_s[7];
      rom_addr_d = win_phase_s[6] ? (6'd0 - win_phase_s[5:0]) : win_phase_s[5:0];
      peak_a_d   = win_phase_s[6] & (win_phase_s[5:0] == 6'd0);
      id_a_d     = win_id_s;
    end else begin
      gnt_d   = '0;
      vld_a_d = 1'b0;
    end
  end

  // Stage C: rebuild the waveforms from the ROM word; outputs hold between results.
  always_comb begin
    mag_s        = peak_b_q ? 8'hFF : rom_data;
    resp_valid_d = vld_b_q;
    resp_ch_d    = resp_ch_q;
    sine_d       = sine_q;
    full_d       = full_q;
    half_d       = half_q;
    if (vld_b_q) begin
      resp_ch_d = id_b_q;
      sine_d    = sign_b_q ? (~mag_s + 8'd1) : mag_s;
      full_d    = mag_s;
      half_d    = sign_b_q ? 8'd127 : mag_s;
    end else begin
      resp_ch_d = resp_ch_q;
    end
    busy_d = vld_a_d | vld_a_q | vld_b_q;
  end

  // Pipeline registers for stages A, B and C.
  always_ff @(posedge clk_star or posedge reset) begin
    if (reset) begin
      gnt_q        <= '0;
      rom_addr_q   <= 6'd0;
      vld_a_q      <= 1'b0;
      sign_a_q     <= 1'b0;
      peak_a_q     <= 1'b0;
      id_a_q       <= '0;
      vld_b_q      <= 1'b0;
      sign_b_q     <= 1'b0;
      peak_b_q     <= 1'b0;
      id_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_ch_q    <= '0;
      sine_q       <= 8'd0;
      full_q       <= 8'd0;
      half_q       <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      rom_addr_q   <= rom_addr_d;
      vld_a_q      <= vld_a_d;
      sign_a_q     <= sign_a_d;
      peak_a_q     <= peak_a_d;
      id_a_q       <= id_a_d;
      vld_b_q      <= vld_a_q;
      sign_b_q     <= sign_a_q;
      peak_b_q     <= peak_a_q;
      id_b_q       <= id_a_q;
      resp_valid_q <= resp_valid_d;
      resp_ch_q    <= resp_ch_d;
      sine_q       <= sine_d;
      full_q       <= full_d;
      half_q       <= half_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign rom_addr   = rom_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_ch    = resp_ch_q;
  assign sine       = sine_q;
  assign full       = full_q;
  assign half       = half_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dds_rom_arbiter.sv
// Scoreboard bench for dds_rom_arbiter: directed scenarios with an external synchronous ROM model.
module tb_dds_rom_arbiter;

  localparam int NCH  = 4;
  localparam int CH_W = 2;

  logic            clk_star = 1'b0;
  logic            reset;
  logic            en;
  logic [NCH-1:0]  req;
  logic [NCH*8-1:0] phase;
  logic [NCH-1:0]  gnt;
  logic [5:0]      rom_addr;
  logic [7:0]      rom_data;
  logic            resp_valid;
  logic [CH_W-1:0] resp_ch;
  logic [7:0]      sine;
  logic [7:0]      full;
  logic [7:0]      half;
  logic            busy;

  logic [7:0]  rom_mem [64];
  logic [25:0] sb [$];
  logic [25:0] exp_r;
  int n_checks = 0;
  int n_fail   = 0;

  dds_rom_arbiter #(.NCH(NCH), .CH_W(CH_W)) dut (
    .clk_star(clk_star), .reset(reset), .en(en), .req(req), .phase(phase),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data), .resp_valid(resp_valid),
    .resp_ch(resp_ch), .sine(sine), .full(full), .half(half), .busy(busy)
  );

  always #5 clk_star = ~clk_star;

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i * 4 + 1);
  end

  always @(posedge clk_star) rom_data <= rom_mem[rom_addr];

  // Expected {ch, sine, full, half} for a given channel and phase byte.
  function automatic logic [25:0] exp_resp(input int ch, input logic [7:0] ph);
    int a, adr, mag, s, h;
    a   = int'(ph[5:0]);
    adr = ph[6] ? ((64 - a) % 64) : a;
    mag = (ph[6] && a == 0) ? 255 : int'(rom_mem[adr]);
    s   = ph[7] ? ((256 - mag) % 256) : mag;
    h   = ph[7] ? 127 : mag;
    return {ch[1:0], s[7:0], mag[7:0], h[7:0]};
  endfunction

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; req = '0; phase = '0;
    repeat (2) @(negedge clk_star);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; req = '0; phase = '0;
    repeat (2) @(negedge clk_star);
    n_checks++;
    if ({gnt, rom_addr, resp_valid, resp_ch, sine, full, half, busy} !== 38'd0) begin
      n_fail++; $display("FAIL reset_hold: outputs=%h expected 0", {gnt, rom_addr, resp_valid, resp_ch, sine, full, half, busy});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_star);
    n_checks++;
    if ({gnt, rom_addr, resp_valid, resp_ch, sine, full, half, busy} !== 38'd0) begin
      n_fail++; $display("FAIL reset_release: outputs=%h expected 0", {gnt, rom_addr, resp_valid, resp_ch, sine, full, half, busy});
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_g;
    en = 1'b1; phase[23:16] = 8'h05; req = 4'b0100;
    sb.push_back(exp_resp(2, 8'h05));
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_star);
      exp_g = (c == 1) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL basic_gnt c%0d: got %b expected %b", c, gnt, exp_g); end
      n_checks++;
      if (resp_valid !== (c == 3)) begin n_fail++; $display("FAIL basic_valid c%0d: got %b expected %b", c, resp_valid, (c == 3)); end
      n_checks++;
      if (busy !== (c <= 3)) begin n_fail++; $display("FAIL basic_busy c%0d: got %b expected %b", c, busy, (c <= 3)); end
      if (c == 1) begin
        n_checks++;
        if (rom_addr !== 6'd5) begin n_fail++; $display("FAIL basic_addr: got %0d expected 5", rom_addr); end
        req = 4'b0000;
      end
      if (resp_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL basic_resp: unexpected result ch=%0d", resp_ch);
        end else begin
          exp_r = sb.pop_front();
          if ({resp_ch, sine, full, half} !== exp_r) begin
            n_fail++; $display("FAIL basic_resp: got %h expected %h", {resp_ch, sine, full, half}, exp_r);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL basic_missing: %0d results outstanding, expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_quadrant();
    logic [13:0] tbl [7];
    tbl = '{{8'h45, 6'd59}, {8'h40, 6'd0}, {8'hC0, 6'd0}, {8'h85, 6'd5},
            {8'hC5, 6'd59}, {8'h3F, 6'd63}, {8'h7F, 6'd1}};
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      phase[15:8] = tbl[k][13:6];
      req = 4'b0010;
      sb.push_back(exp_resp(1, tbl[k][13:6]));
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk_star);
        if (c == 1) begin
          n_checks++;
          if (gnt !== 4'b0010 || rom_addr !== tbl[k][5:0]) begin
            n_fail++; $display("FAIL quad_addr ph=%h: gnt=%b addr=%0d expected gnt=0010 addr=%0d", tbl[k][13:6], gnt, rom_addr, tbl[k][5:0]);
          end
          req = 4'b0000;
        end
        if (c == 3) begin
          n_checks++;
          if (resp_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL quad_valid ph=%h: resp_valid=%b expected 1", tbl[k][13:6], resp_valid);
          end else begin
            exp_r = sb.pop_front();
            if ({resp_ch, sine, full, half} !== exp_r) begin
              n_fail++; $display("FAIL quad_resp ph=%h: got %h expected %h", tbl[k][13:6], {resp_ch, sine, full, half}, exp_r);
            end
          end
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_round_robin();
    int seq [6];
    logic [3:0] exp_g;
    int n_resp;
`ifdef DDS_ARB_PRIORITY_EN
    seq = '{0, 1, 0, 1, 0, 1};
`else
    seq = '{0, 1, 2, 3, 0, 1};
`endif
    do_reset();
    phase = {8'hD0, 8'h8A, 8'h47, 8'h03};
    for (int k = 0; k < 6; k++) sb.push_back(exp_resp(seq[k], phase[8*seq[k] +: 8]));
    en = 1'b1; req = 4'b1111; n_resp = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_star);
      exp_g = (c <= 6) ? (4'b0001 << seq[c-1]) : 4'b0000;
      n_checks++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, exp_g); end
      n_checks++;
      if (resp_valid !== (c >= 3 && c <= 8)) begin n_fail++; $display("FAIL rr_valid c%0d: got %b expected %b", c, resp_valid, (c >= 3 && c <= 8)); end
      if (c == 6) req = 4'b0000;
      if (resp_valid === 1'b1) begin
        n_resp++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rr_resp: unexpected result ch=%0d", resp_ch);
        end else begin
          exp_r = sb.pop_front();
          if ({resp_ch, sine, full, half} !== exp_r) begin
            n_fail++; $display("FAIL rr_resp c%0d: got %h expected %h", c, {resp_ch, sine, full, half}, exp_r);
          end
        end
      end
    end
    n_checks++;
    if (n_resp != 6) begin n_fail++; $display("FAIL rr_count: got %0d results expected 6", n_resp); end
    sb.delete();
  endtask

  task automatic test_single_channel();
    logic [3:0] exp_g;
    phase[7:0] = 8'hA9;
    repeat (3) sb.push_back(exp_resp(0, 8'hA9));
    en = 1'b1; req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_star);
      exp_g = (c == 1 || c == 3 || c == 5) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL single_gnt c%0d: got %b expected %b", c, gnt, exp_g); end
      if (c == 5) req = 4'b0000;
      n_checks++;
      if (resp_valid !== (c == 3 || c == 5 || c == 7)) begin
        n_fail++; $display("FAIL single_valid c%0d: got %b expected %b", c, resp_valid, (c == 3 || c == 5 || c == 7));
      end
      if (resp_valid === 1'b1 && sb.size() != 0) begin
        exp_r = sb.pop_front();
        n_checks++;
        if ({resp_ch, sine, full, half} !== exp_r) begin
          n_fail++; $display("FAIL single_resp c%0d: got %h expected %h", c, {resp_ch, sine, full, half}, exp_r);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL single_missing: %0d results outstanding, expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_drain();
    int seq [3];
    logic [3:0] exp_g;
    int n_resp;
`ifdef DDS_ARB_PRIORITY_EN
    seq = '{0, 1, 0};
`else
    seq = '{0, 1, 2};
`endif
    do_reset();
    phase = {8'h11, 8'hE2, 8'h60, 8'h1F};
    for (int k = 0; k < 3; k++) sb.push_back(exp_resp(seq[k], phase[8*seq[k] +: 8]));
    en = 1'b1; req = 4'b1111; n_resp = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_star);
      exp_g = (c <= 3) ? (4'b0001 << seq[c-1]) : 4'b0000;
      n_checks++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL drain_gnt c%0d: got %b expected %b", c, gnt, exp_g); end
      n_checks++;
      if (busy !== (c <= 5)) begin n_fail++; $display("FAIL drain_busy c%0d: got %b expected %b", c, busy, (c <= 5)); end
      if (c == 3) en = 1'b0;
      if (c == 4) req = 4'b0110;
      if (resp_valid === 1'b1) begin
        n_resp++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL drain_resp: unexpected result ch=%0d", resp_ch);
        end else begin
          exp_r = sb.pop_front();
          if ({resp_ch, sine, full, half} !== exp_r) begin
            n_fail++; $display("FAIL drain_resp c%0d: got %h expected %h", c, {resp_ch, sine, full, half}, exp_r);
          end
        end
      end
    end
    n_checks++;
    if (n_resp != 3) begin n_fail++; $display("FAIL drain_count: got %0d results expected 3", n_resp); end
    req = 4'b0000; en = 1'b1;
    @(negedge clk_star);
    // request rises in the same cycle that en falls
    req = 4'b1000; en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_star);
      n_checks++;
      if (gnt !== 4'b0000 || resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL en_fall_gnt c%0d: gnt=%b resp_valid=%b expected 0000/0", c, gnt, resp_valid);
      end
    end
    req = 4'b0000;
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    en = 1'b1; phase = {8'h00, 8'h22, 8'h11, 8'h33}; req = 4'b0110;
    @(negedge clk_star);
    n_checks++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_gnt1: got %b expected 0010", gnt); end
    @(negedge clk_star);
    n_checks++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_gnt2: got %b expected 0100", gnt); end
    req = 4'b0000;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({gnt, rom_addr, resp_valid, resp_ch, sine, full, half, busy} !== 38'd0) begin
      n_fail++; $display("FAIL mid_reset_out: outputs=%h expected 0", {gnt, rom_addr, resp_valid, resp_ch, sine, full, half, busy});
    end
    @(negedge clk_star);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_star);
      n_checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || full !== 8'd0) begin
        n_fail++; $display("FAIL mid_discard c%0d: resp_valid=%b busy=%b full=%h expected 0/0/00", c, resp_valid, busy, full);
      end
    end
    req = 4'b1111;
    sb.push_back(exp_resp(0, 8'h33));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_star);
      if (c == 1) begin
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_gnt: got %b expected 0001", gnt); end
        req = 4'b0000;
      end
    end
    n_checks++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL mid_restart_valid: got %b expected 1", resp_valid);
    end else begin
      exp_r = sb.pop_front();
      if ({resp_ch, sine, full, half} !== exp_r) begin
        n_fail++; $display("FAIL mid_restart_resp: got %h expected %h", {resp_ch, sine, full, half}, exp_r);
      end
    end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_quadrant();
    test_round_robin();
    test_single_channel();
    test_drain();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_rom_arbiter.md
Name: dds_rom_arbiter

Overview:
- Time-shares one quarter-wave sine ROM (64 x 8, synchronous read) between NCH DDS phase-accumulator channels.
- Arbitrates channel requests, folds each granted phase into a ROM address and reconstructs the sine, full and half waveforms per channel.
- Sits between the per-channel phase accumulators and the single shared ROM instance.
- Returns results tagged with the channel id.

Parameters:
NCH, 4, number of requesting channels (2..8)
CH_W, 2, channel-id width, equal to clog2(NCH)

Ports:
clk_star  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  1 = grant new requests; 0 = no new grants, pipeline drains
req  in  NCH  per-channel request; held with phase until granted
phase  in  NCH*8  per-channel phase, channel i at [8i+7:8i]; bit7 = sign, bit6 = quadrant, bits5:0 = address
gnt  out  NCH  one-hot grant, 1-cycle pulse
rom_addr  out  6  address to the shared ROM
rom_data  in  8  ROM word, valid 1 cycle after rom_addr
resp_valid  out  1  result strobe, 1 cycle
resp_ch  out  CH_W  channel id of the result
sine  out  8  signed-style sine sample
full  out  8  full-wave rectified magnitude
half  out  8  half-wave output
busy  out  1  any pipeline stage holds a valid transaction

Behaviour:
- Reset (async): gnt=0, rom_addr=0, resp_valid=0, resp_ch=0, sine=0, full=0, half=0, busy=0, RR pointer=0, all stage-valid bits cleared.
- Reset asserted mid-operation: in-flight transactions are discarded, with no resp_valid for them.
- Stage A, at edge T+1 for a request sampled at T:
  - eligible = req & ~gnt. A channel granted this cycle is ineligible this cycle; if its req is still high next cycle, that is a new request.
  - Round-robin arbitration: search starts at pointer; the winner gets gnt for one cycle; the pointer becomes winner+1 mod NCH.
  - No grant if en=0 or no channel is eligible; the pointer is then unchanged.
  - Register the winner's phase fields: sign = phase[7], q = phase[6], a = phase[5:0].
  - rom_addr = q ? (64 - a) mod 64 : a, i.e. two's-complement negate in 6 bits.
  - peak = q & (a == 0).
  - With no grant, rom_addr holds its previous value.
- Stage B, edge T+2: ROM returns rom_data. Sign, peak, channel id and valid are delayed to align with it.
- Stage C, edge T+3, registered outputs:
  - mag = peak ? 8'hFF : rom_data.
  - sine = sign ? (~mag + 1) mod 256 : mag.
  - full = mag.
  - half = sign ? 8'd127 : mag.
  - resp_valid = 1 and resp_ch = id.
- Outputs hold their last value when resp_valid=0.
- Latency: 3 cycles from the req sample to resp_valid.
- Throughput: 1 transaction per cycle overall; any single channel is granted at most every other cycle.
- busy = OR of the stage A/B/C valid bits.
- en falling: no new grant from that edge on; up to 3 queued results still emerge; busy falls after the last one.
- NCH not a power of 2: pointer wraps from NCH-1 to 0; ids >= NCH are never produced.
- Simultaneous req rise and en fall: no grant.

Optional Feature:
DDS_ARB_PRIORITY_EN:
- Defined: fixed priority, lowest-indexed eligible channel wins; the RR pointer is removed.
- Undefined (default): round-robin as above.
- The gnt-mask rule and pipeline timing are identical in both builds.

Test Plan:
- Reset release -> all outputs 0, busy 0; req=4'b0100, phase[2]=8'h05, en=1 at T -> gnt=4'b0100 at T+1, rom_addr=5, resp_valid at T+3 with resp_ch=2, full=ROM[5], sine=ROM[5], half=ROM[5].
- Quadrant fold: phase 8'h45 -> rom_addr=59. Peak: phase 8'h40 -> full=8'hFF, sine=8'hFF, half=8'hFF. Phase 8'hC0 -> full=8'hFF, sine=8'h01, half=8'h7F.
- All four req held high -> gnt sequence 0,1,2,3,0,1 on consecutive cycles; resp_ch follows 3 cycles later. With DDS_ARB_PRIORITY_EN -> gnt alternates 0,1,0,1 (0 masked every other cycle).
- Single channel req held high -> gnt on alternate cycles only.
- en dropped with 3 transactions in flight -> exactly 3 more resp_valid, no new gnt, busy falls the cycle after the last.
- reset pulsed with 2 transactions in flight -> no resp_valid afterwards, outputs 0, next grant starts at channel 0.
